serial_parity_rx: RTL
=====================

Name: serial_parity_rx

Overview:
Receiver end of the team's parity-protected serial link: deserialises one frame per transfer and checks its XOR parity bit. The peer is the link's parity transmitter.
- Frame, in bit order: start (0), DATA_W data bits LSB first, parity bit, stop (1).
- Presents the recovered word with a one-cycle valid pulse plus parity and framing error flags.
- Sits between the serial pin-level interface and byte-wide consumer logic in the simple CADD datapath.

Parameters:
DATA_W, 8, data bits per frame (2..32)
ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
bit_en  input  1  bit-time strobe; serial_in is sampled only on clk edges where bit_en=1
serial_in  input  1  serial line, idles high
data_out  output  DATA_W  last received data word
data_valid  output  1  one-cycle pulse: frame complete, data_out and flags valid
parity_err  output  1  parity mismatch for the last completed frame
frame_err  output  1  stop bit sampled as 0 for the last completed frame
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, any state, mid-frame included): state=IDLE, bit counter=0, shift register=0. Outputs: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0. A partial frame is discarded.
- All state changes occur only on clk edges with bit_en=1. With bit_en=0 the FSM, counter and shift register hold, and data_valid=0.
- IDLE: if serial_in=1 on a bit_en edge, stay in IDLE. If serial_in=0, go to DATA with counter=0. No start-bit revalidation.
- DATA: each bit_en edge shifts serial_in into the MSB of the shift register (right shift), so after DATA_W bits the LSB-first word is aligned. The counter increments; on the edge that samples bit DATA_W-1, go to PARITY.
- PARITY: on the bit_en edge, compute mismatch = (^shift_reg) ^ serial_in ^ ODD_PARITY, store it internally, and go to STOP.
- STOP: on the bit_en edge, in the same edge:
  - data_out <= shift register
  - parity_err <= stored mismatch
  - frame_err <= ~serial_in
  - data_valid <= 1
  - go to IDLE
- data_valid is high for exactly the one clk cycle after that edge, independent of bit_en.
- A frame with errors is still delivered: data_valid pulses and the flags are set.
- data_out, parity_err and frame_err hold until the next frame completes or reset.
- No backpressure and no overrun detection. The consumer must take the word during the data_valid cycle.
- Back-to-back frames: a start bit sampled on the bit_en edge immediately after STOP is accepted.
- Latency: data_valid rises 1 clk after the bit_en edge that samples the stop bit.
- Counter width: $clog2(DATA_W).

Decomposition:
- Shared package: state enum (IDLE, DATA, PARITY, STOP) and the frame-field constants (START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1), so the transmitter and the benches use the same definitions.
- No sub-module. The parity reduction is a single XOR expression, and the FSM, counter and shift register fit in one module.

Test Plan:
- Reset, then DATA_W=8 even parity, bit_en every cycle, send 0xA5 with parity 0, stop 1 -> data_out=0xA5, data_valid pulses once, parity_err=0, frame_err=0, busy falls with the pulse.
- Send 0x01 with parity bit 0 (even mode) -> data_out=0x01, parity_err=1, frame_err=0. Then send 0x03 with parity 0 -> parity_err clears to 0.
- Send 0x5A with correct parity and stop bit 0 -> data_valid pulses, data_out=0x5A, frame_err=1, parity_err=0.
- bit_en asserted only every 16th cycle, line held high between strobes, send 0xC3 -> same result as continuous strobing, exactly one data_valid pulse, state frozen between strobes.
- Assert rst for 1 cycle after 3 data bits of a frame -> all outputs 0 and busy=0 immediately (async). A following full 0x3C frame is received correctly with no spurious pulse.
- Back-to-back frames 0x00 then 0xFF, start bit directly after stop, run once with ODD_PARITY=1 and correct odd parity bits -> two data_valid pulses with data_out 0x00 then 0xFF, no error flags.

Source files
------------

// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the parity-protected serial link: receiver FSM states
// and frame field levels used by both ends of the link and by the benches.
package serial_parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_parity_rx.sv
// Parity-checking serial receiver: start, DATA_W bits LSB first, parity, stop.
// Delivers every frame with a one-cycle valid pulse, errored frames included.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit
// DATA   | shifting in data bits, LSB first
// PARITY | sampling the parity bit, latching the mismatch
// STOP   | sampling the stop bit, publishing word and flags
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic            PAR_SENSE = (ODD_PARITY != 0);

  rx_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_mismatch <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (serial_in == START_BIT) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            // Right shift: the first (LSB) bit ends up in bit 0 after DATA_W shifts
            shift_reg <= {serial_in, shift_reg[DATA_W-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_mismatch <= (^shift_reg) ^ serial_in ^ PAR_SENSE;
            state        <= STOP;
          end
          STOP: begin
            data_out   <= shift_reg;
            parity_err <= par_mismatch;
            frame_err  <= (serial_in != STOP_BIT);
            data_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
